// File: rtl/pdts_pkg.sv
// rtl/pdts_pkg.sv - shared constants and helpers for the timing-endpoint PLL supervisor
package pdts_pkg;

  // One-hot state bit positions for pdts_pll_lock_ctrl
  localparam int IDX_RESET_PLL = 0;
  localparam int IDX_WAIT_LOCK = 1;
  localparam int IDX_STABLE    = 2;
  localparam int IDX_READY     = 3;
  localparam int IDX_FAULT     = 4;
  localparam int STATE_W       = 5;

  typedef logic [STATE_W-1:0] pll_state_t;

  localparam logic [4:0] ST_RESET_PLL = 5'b00001;
  localparam logic [4:0] ST_WAIT_LOCK = 5'b00010;
  localparam logic [4:0] ST_STABLE    = 5'b00100;
  localparam logic [4:0] ST_READY     = 5'b01000;
  localparam logic [4:0] ST_FAULT     = 5'b10000;

  function automatic int clog2max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pdts_sync_bit.sv
// rtl/pdts_sync_bit.sv - two-flop synchroniser for a single asynchronous level
module pdts_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pdts_pll_lock_ctrl.sv
// rtl/pdts_pll_lock_ctrl.sv - PLL reset/lock supervisor with retry, fault latch and lock-loss count
module pdts_pll_lock_ctrl
  import pdts_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 8,
  parameter int LOSS_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              locked,
  output logic              pll_rst,
  output logic              rdy,
  output logic              fault,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int CNT_W   = clog2max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  pll_state_t         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               locked_s;
  logic               loss_evt;

  pdts_sync_bit u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    loss_evt  = 1'b0;
    if (soft_rst) begin
      state_nxt = ST_RESET_PLL;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = ST_STABLE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            retry_nxt = retry + RETRY_W'(1);
            state_nxt = (retry_nxt == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_RESET_PLL;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state_nxt = ST_WAIT_LOCK;
          end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
            state_nxt = ST_READY;
            retry_nxt = '0;
          end
        end
        ST_READY: begin
          if (!locked_s) begin
            state_nxt = ST_RESET_PLL;
            loss_evt  = 1'b1;
          end
        end
        ST_FAULT: state_nxt = ST_FAULT;
        default:  state_nxt = ST_RESET_PLL;
      endcase
    end
  end

  // cnt restarts on any state change; soft_rst also pins it while RESET_PLL is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET_PLL;
      cnt       <= '0;
      retry     <= '0;
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      retry     <= retry_nxt;
      lock_lost <= loss_evt;
      if (soft_rst || (state_nxt != state)) cnt <= '0;
      else                                  cnt <= cnt + CNT_W'(1);
      if (loss_evt && (loss_cnt != '1)) loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign pll_rst = state[IDX_RESET_PLL];
  assign rdy     = state[IDX_READY];
  assign fault   = state[IDX_FAULT];

endmodule

// File: tb/tb_pdts_pll_lock_ctrl.sv
// tb/tb_pdts_pll_lock_ctrl.sv - directed self-checking bench for pdts_pll_lock_ctrl
module tb_pdts_pll_lock_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 64;
  localparam int LOCK_STABLE  = 8;
  localparam int MAX_RETRY    = 3;
  localparam int LOSS_W       = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              soft_rst;
  logic              locked;
  logic              pll_rst;
  logic              rdy;
  logic              fault;
  logic              lock_lost;
  logic [LOSS_W-1:0] loss_cnt;

  int checks   = 0;
  int failures = 0;

  always #10 clk = ~clk;

  pdts_pll_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRY    (MAX_RETRY),
    .LOSS_W       (LOSS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_rst  (soft_rst),
    .locked    (locked),
    .pll_rst   (pll_rst),
    .rdy       (rdy),
    .fault     (fault),
    .lock_lost (lock_lost),
    .loss_cnt  (loss_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      tick(1);
      if (rdy === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; soft_rst = 1'b0; locked = 1'b0;
    tick(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
    checks++; if (loss_cnt !== 4'd0) begin failures++; $display("FAIL reset_loss_cnt got=%0d exp=0", loss_cnt); end
  endtask

  task automatic test_power_on();
    logic exp;
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      exp = (i < RST_CYCLES);
      checks++; if (pll_rst !== exp) begin failures++; $display("FAIL por_pll_rst_edge%0d got=%b exp=%b", i, pll_rst, exp); end
    end
    tick(10);
    locked = 1'b1;
    tick(10);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL por_rdy_early got=%b exp=0", rdy); end
    tick(1);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL por_rdy_edge11 got=%b exp=1", rdy); end
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL por_ready_pll_rst got=%b exp=0", pll_rst); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    locked = 1'b0;
    tick(2);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL loss_rdy_edge2 got=%b exp=1", rdy); end
    tick(1);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL loss_rdy_edge3 got=%b exp=0", rdy); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst_edge3 got=%b exp=1", pll_rst); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL loss_pulse got=%b exp=1", lock_lost); end
    checks++; if (loss_cnt !== 4'd1) begin failures++; $display("FAIL loss_cnt got=%0d exp=1", loss_cnt); end
    tick(1);
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL loss_pulse_width got=%b exp=0", lock_lost); end
    locked = 1'b1;
    wait_rdy(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL loss_relock_timeout got=%b exp=1", ok); end
    checks++; if (loss_cnt !== 4'd1) begin failures++; $display("FAIL loss_cnt_after_relock got=%0d exp=1", loss_cnt); end
  endtask

  task automatic test_timeout_fault();
    logic prev;
    int rises, r1, r2, highs, fault_at, bad;
    locked = 1'b0;
    do_reset();
    prev = 1'b1; rises = 0; r1 = 0; r2 = 0; highs = 0; fault_at = 0; bad = 0;
    for (int i = 1; i <= 220; i++) begin
      tick(1);
      if (pll_rst && !prev) begin
        rises++;
        if (rises == 1) r1 = i;
        else if (rises == 2) r2 = i;
      end
      if (pll_rst) highs++;
      if (fault && fault_at == 0) fault_at = i;
      prev = pll_rst;
    end
    checks++; if (rises !== 2) begin failures++; $display("FAIL to_retry_pulses got=%0d exp=2", rises); end
    checks++; if (r1 !== 68) begin failures++; $display("FAIL to_pulse2_start got=%0d exp=68", r1); end
    checks++; if (r2 !== 136) begin failures++; $display("FAIL to_pulse3_start got=%0d exp=136", r2); end
    checks++; if (highs !== 11) begin failures++; $display("FAIL to_pll_rst_high_cycles got=%0d exp=11", highs); end
    checks++; if (fault_at !== 204) begin failures++; $display("FAIL to_fault_edge got=%0d exp=204", fault_at); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL to_fault_rdy got=%b exp=0", rdy); end
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (fault !== 1'b1 || pll_rst !== 1'b0 || rdy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL to_fault_hold bad_cycles got=%0d exp=0", bad); end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL soft_fault_clear got=%b exp=0", fault); end
    highs = (pll_rst === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      if (pll_rst) highs++;
    end
    checks++; if (highs !== 4) begin failures++; $display("FAIL soft_pulse_len got=%0d exp=4", highs); end
    soft_rst = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pll_rst) highs++;
    end
    soft_rst = 1'b0;
    checks++; if (highs !== 10) begin failures++; $display("FAIL soft_hold_pll_rst got=%0d exp=10", highs); end
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (pll_rst) highs++;
    end
    checks++; if (highs !== 3) begin failures++; $display("FAIL soft_hold_release_len got=%0d exp=3", highs); end
  endtask

  task automatic test_stable_glitch();
    int rdy_hi, rst_hi, rises, r1, r2, fault_at;
    logic prev;
    locked = 1'b0;
    do_reset();
    tick(8);
    locked = 1'b1;
    rdy_hi = 0; rst_hi = 0;
    for (int i = 9; i <= 29; i++) begin
      tick(1);
      if (rdy) rdy_hi++;
      if (pll_rst) rst_hi++;
      if (i == 16) locked = 1'b0;
      if (i == 19) locked = 1'b1;
    end
    checks++; if (rdy_hi !== 0) begin failures++; $display("FAIL glitch_no_rdy got=%0d exp=0", rdy_hi); end
    checks++; if (rst_hi !== 0) begin failures++; $display("FAIL glitch_no_pll_rst got=%0d exp=0", rst_hi); end
    tick(1);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL glitch_full_window_rdy got=%b exp=1", rdy); end
    locked = 1'b0;
    do_reset();
    prev = 1'b1; rises = 0; r1 = 0; r2 = 0; fault_at = 0;
    for (int i = 1; i <= 220; i++) begin
      tick(1);
      if (pll_rst && !prev) begin
        rises++;
        if (rises == 1) r1 = i;
        else if (rises == 2) r2 = i;
      end
      if (fault && fault_at == 0) fault_at = i;
      prev = pll_rst;
      if (i == 72) locked = 1'b1;
      if (i == 77) locked = 1'b0;
    end
    checks++; if (r1 !== 68) begin failures++; $display("FAIL retry_pulse2 got=%0d exp=68", r1); end
    checks++; if (r2 !== 144) begin failures++; $display("FAIL retry_pulse3 got=%0d exp=144", r2); end
    checks++; if (fault_at !== 212) begin failures++; $display("FAIL retry_kept_fault_edge got=%0d exp=212", fault_at); end
  endtask

  task automatic test_loss_saturation();
    bit ok;
    int pulses;
    logic [LOSS_W-1:0] exp_cnt;
    locked = 1'b1;
    do_reset();
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      wait_rdy(100, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sat_wait_rdy iter=%0d got=%b exp=1", k, ok); end
      locked = 1'b0;
      for (int j = 0; j < 6; j++) begin
        tick(1);
        if (lock_lost) pulses++;
      end
      exp_cnt = (k > 15) ? 4'd15 : LOSS_W'(k);
      checks++; if (loss_cnt !== exp_cnt) begin failures++; $display("FAIL sat_loss_cnt iter=%0d got=%0d exp=%0d", k, loss_cnt, exp_cnt); end
      locked = 1'b1;
    end
    checks++; if (pulses !== 20) begin failures++; $display("FAIL sat_pulse_count got=%0d exp=20", pulses); end
    wait_rdy(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL sat_final_rdy got=%b exp=1", ok); end
    soft_rst = 1'b1;
    tick(1);
    soft_rst = 1'b0;
    checks++; if (loss_cnt !== 4'd15) begin failures++; $display("FAIL soft_keeps_loss_cnt got=%0d exp=15", loss_cnt); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL soft_no_lock_lost got=%b exp=0", lock_lost); end
    checks++; if (pll_rst !== 1'b1 || rdy !== 1'b0) begin failures++; $display("FAIL soft_from_ready got=pll_rst%b/rdy%b exp=1/0", pll_rst, rdy); end
  endtask

  task automatic test_async_reset();
    bit ok;
    tick(8);
    #3 rst = 1'b1;
    #1;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL async_stable_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (loss_cnt !== 4'd0) begin failures++; $display("FAIL async_stable_loss_cnt got=%0d exp=0", loss_cnt); end
    checks++; if (rdy !== 1'b0 || fault !== 1'b0 || lock_lost !== 1'b0) begin failures++; $display("FAIL async_stable_flags got=%b%b%b exp=000", rdy, fault, lock_lost); end
    @(negedge clk);
    rst = 1'b0;
    tick(12);
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL restart_rdy_early got=%b exp=0", rdy); end
    tick(1);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL restart_rdy_edge13 got=%b exp=1", rdy); end
    tick(3);
    #3 rst = 1'b1;
    #1;
    checks++; if (rdy !== 1'b0 || pll_rst !== 1'b1) begin failures++; $display("FAIL async_ready got=rdy%b/pll_rst%b exp=0/1", rdy, pll_rst); end
    @(negedge clk);
    rst = 1'b0;
    wait_rdy(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL async_ready_restart got=%b exp=1", ok); end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_lock_loss();
    test_timeout_fault();
    test_stable_glitch();
    test_loss_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
